phase_sequencer: RTL and testbench
==================================

# phase_sequencer

Instruction-step sequencer that sits directly downstream of the four-phase clock generator and consumes its Phi1..Phi4 strobes. It tracks the four-phase cycle as fetch/decode/execute/writeback and issues one-cycle registered enables to the datapath. It also handles memory-not-ready stalls, a halt request and phase-order faults, and keeps saturating instruction and stall counters.

## Interface
Parameters:
- COUNT_W, 16, width of instrCount and stallCount

Ports:
- inClock  in  1  system clock; Phi1..Phi4 are generated in this same domain
- Reset  in  1  asynchronous, active-low reset (0 = reset)
- Phi1  in  1  fetch phase strobe
- Phi2  in  1  decode phase strobe
- Phi3  in  1  execute phase strobe
- Phi4  in  1  writeback phase strobe
- memReady  in  1  instruction memory ready, sampled with Phi1
- haltReq  in  1  halt request, sampled with Phi4
- fetchEn  out  1  latch instruction (one cycle)
- decodeEn  out  1  register-file read and decode (one cycle)
- execEn  out  1  ALU/memory execute (one cycle)
- writeEn  out  1  register writeback (one cycle)
- running  out  1  1 while in FETCH..WRITEBACK states
- halted  out  1  sticky until reset
- phaseError  out  1  sticky until reset
- instrCount  out  COUNT_W  completed writebacks, saturating
- stallCount  out  COUNT_W  lost instruction slots, saturating

## Operation
- Clock and reset conventions:
  - Reset is asynchronous and active-low on Reset.
  - All logic is clocked on rising inClock.
- The phase vector is {Phi4,Phi3,Phi2,Phi1}. "Valid" means exactly one bit is set.
- FSM states: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALTED, ERROR. Reset state is IDLE.
- IDLE:
  - Phi1 with memReady=1 -> FETCH.
  - Phi1 with memReady=0 -> stay in IDLE and increment stallCount.
  - Any other valid phase -> stay in IDLE (waiting for alignment).
  - Invalid vector -> ERROR.
- FETCH -> DECODE on Phi2.
- DECODE -> EXECUTE on Phi3.
- EXECUTE -> WRITEBACK on Phi4.
- WRITEBACK:
  - Phi1 with haltReq=0 and memReady=1 -> FETCH.
  - Phi1 with haltReq=0 and memReady=0 -> IDLE, and stallCount increments.
  - If haltReq was 1 at the Phi4 sample that entered WRITEBACK, the state goes to HALTED instead.
- In any of FETCH..WRITEBACK, a valid phase other than the expected one, or an invalid vector, goes to ERROR.
- Enables are set on the edge that enters a state and clear on the next edge:
  - fetchEn with FETCH, decodeEn with DECODE, execEn with EXECUTE, writeEn with WRITEBACK.
  - At most one enable is high in any cycle.
- instrCount increments on the edge that enters WRITEBACK and saturates at all-ones.
- stallCount increments once per Phi1 sampled with memReady=0 while in IDLE or WRITEBACK, and saturates at all-ones.
- HALTED and ERROR are absorbing: all enables stay 0 and only Reset exits them.
- Simultaneous events:
  - An invalid vector wins over haltReq and memReady.
  - haltReq takes effect only on the Phi4 sample.
  - A memReady drop outside Phi1 is ignored.

## Timing
- Reset values: every output is 0, and both counters are 0.
- Latency: 1 cycle from the phase sample to the enable output. With the free-running generator, each enable is therefore aligned to the phase that follows the strobe it was decoded from.
- Throughput: one instruction per 4 inClock cycles when there are no stalls. Each stall costs a full 4-cycle slot.
- Reset mid-operation: outputs go to 0 immediately (asynchronously). After release, the block waits in IDLE for the next Phi1.
- An all-zero phase vector in IDLE directly after reset counts as invalid and goes to ERROR.

## Structure
- Shared package phase_seq_pkg holds:
  - the state enum,
  - the phase index constants (PH_FETCH=0 .. PH_WB=3),
  - the COUNT_W default.
- One natural sub-module: phase_onehot_check. It is combinational: 4-bit vector in, {valid, index[1:0]} out. The FSM compares the index against the expected index.
- Counters are instantiated inline as saturating registers.

## Test plan
- Reset low for 2 cycles, then released, with the generator running and memReady=1, haltReq=0 for 12 cycles:
  - every output reads 0 during reset,
  - fetchEn, decodeEn, execEn, writeEn each pulse once per 4 cycles, in that order,
  - instrCount=2 at the end.
- memReady=0 on one Phi1:
  - no fetchEn in that slot,
  - stallCount=1,
  - the next Phi1 with memReady=1 restarts at FETCH,
  - instrCount is unchanged by the lost slot.
- haltReq=1 on the 3rd Phi4:
  - that writeEn still pulses and instrCount=3,
  - halted=1 on the following Phi1,
  - no further enables for 20 cycles.
- Phi3 forced where Phi2 is expected, or Phi1 and Phi2 both high: phaseError=1 the next cycle, enables 0, sticky until Reset.
- COUNT_W=2 over 6 instructions: instrCount holds at 3.
- Reset asserted during EXECUTE: outputs drop to 0 immediately, and no writeEn appears for that instruction.

Source files
------------

// File: rtl/phase_seq_pkg.sv
// Shared types and constants for the four-phase instruction sequencer.
package phase_seq_pkg;

    localparam int unsigned COUNT_W_DEFAULT = 16;

    // Bit positions of the strobes within {Phi4,Phi3,Phi2,Phi1}.
    localparam logic [1:0] PH_FETCH  = 2'd0;
    localparam logic [1:0] PH_DECODE = 2'd1;
    localparam logic [1:0] PH_EXEC   = 2'd2;
    localparam logic [1:0] PH_WB     = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExecute,
        StWriteback,
        StHalted,
        StError
    } seq_state_e;

endpackage

// File: rtl/phase_onehot_check.sv
// Classifies a 4-bit phase vector: valid when exactly one strobe is set, plus its index.
module phase_onehot_check (
    input  logic [3:0] phase,
    output logic       valid,
    output logic [1:0] index
);

    always_comb begin
        valid = 1'b1;
        index = 2'd0;
        case (phase)
            4'b0001: index = 2'd0;
            4'b0010: index = 2'd1;
            4'b0100: index = 2'd2;
            4'b1000: index = 2'd3;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/phase_sequencer.sv
// Fetch/decode/execute/writeback sequencer driven by four-phase strobes, with stall,
// halt and phase-fault handling and saturating instruction/stall counters.
module phase_sequencer
    import phase_seq_pkg::*;
#(
    parameter int unsigned COUNT_W = COUNT_W_DEFAULT
) (
    input  logic               inClock,
    input  logic               Reset,
    input  logic               Phi1,
    input  logic               Phi2,
    input  logic               Phi3,
    input  logic               Phi4,
    input  logic               memReady,
    input  logic               haltReq,
    output logic               fetchEn,
    output logic               decodeEn,
    output logic               execEn,
    output logic               writeEn,
    output logic               running,
    output logic               halted,
    output logic               phaseError,
    output logic [COUNT_W-1:0] instrCount,
    output logic [COUNT_W-1:0] stallCount
);

    seq_state_e state;
    logic       halt_pending;
    logic       ph_valid;
    logic [1:0] ph_idx;
    logic [1:0] exp_idx;
    logic       in_cycle;
    logic       phase_fault;

    phase_onehot_check u_check (
        .phase (({Phi4, Phi3, Phi2, Phi1})),
        .valid (ph_valid),
        .index (ph_idx)
    );

    always_comb begin
        exp_idx = PH_FETCH;
        case (state)
            StFetch:     exp_idx = PH_DECODE;
            StDecode:    exp_idx = PH_EXEC;
            StExecute:   exp_idx = PH_WB;
            default:     exp_idx = PH_FETCH;
        endcase
    end

    assign in_cycle = (state == StFetch) || (state == StDecode) ||
                      (state == StExecute) || (state == StWriteback);

    // IDLE tolerates any valid phase while waiting for Phi1; in-cycle states need the next one.
    assign phase_fault = (state != StHalted) && (state != StError) &&
                         (!ph_valid || (in_cycle && (ph_idx != exp_idx)));

    always_ff @(posedge inClock or negedge Reset) begin
        if (!Reset) begin
            state        <= StIdle;
            halt_pending <= 1'b0;
            fetchEn      <= 1'b0;
            decodeEn     <= 1'b0;
            execEn       <= 1'b0;
            writeEn      <= 1'b0;
            running      <= 1'b0;
            halted       <= 1'b0;
            phaseError   <= 1'b0;
            instrCount   <= '0;
            stallCount   <= '0;
        end else begin
            fetchEn  <= 1'b0;
            decodeEn <= 1'b0;
            execEn   <= 1'b0;
            writeEn  <= 1'b0;
            if (phase_fault) begin
                state      <= StError;
                phaseError <= 1'b1;
                running    <= 1'b0;
            end else begin
                case (state)
                    StIdle: begin
                        if (ph_idx == PH_FETCH) begin
                            if (memReady) begin
                                state   <= StFetch;
                                fetchEn <= 1'b1;
                                running <= 1'b1;
                            end else if (~&stallCount) begin
                                stallCount <= stallCount + 1'b1;
                            end
                        end
                    end
                    StFetch: begin
                        state    <= StDecode;
                        decodeEn <= 1'b1;
                    end
                    StDecode: begin
                        state  <= StExecute;
                        execEn <= 1'b1;
                    end
                    StExecute: begin
                        state        <= StWriteback;
                        writeEn      <= 1'b1;
                        halt_pending <= haltReq;
                        if (~&instrCount) begin
                            instrCount <= instrCount + 1'b1;
                        end
                    end
                    StWriteback: begin
                        // Phase already known to be Phi1 here.
                        if (halt_pending) begin
                            state   <= StHalted;
                            halted  <= 1'b1;
                            running <= 1'b0;
                        end else if (memReady) begin
                            state   <= StFetch;
                            fetchEn <= 1'b1;
                        end else begin
                            state   <= StIdle;
                            running <= 1'b0;
                            if (~&stallCount) begin
                                stallCount <= stallCount + 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_phase_sequencer.sv
// Scoreboard bench: stimulus pushes model predictions, a monitor pops and compares after
// each rising edge. A second instance with COUNT_W=2 checks counter saturation.
module tb_phase_sequencer;

    logic inClock = 1'b0;
    logic Reset = 1'b0;
    logic Phi1 = 1'b0, Phi2 = 1'b0, Phi3 = 1'b0, Phi4 = 1'b0;
    logic memReady = 1'b0, haltReq = 1'b0;

    logic fetchEn, decodeEn, execEn, writeEn, running, halted, phaseError;
    logic [15:0] instrCount, stallCount;
    logic s_fetchEn, s_decodeEn, s_execEn, s_writeEn, s_running, s_halted, s_phaseError;
    logic [1:0] s_instrCount, s_stallCount;

    always #5 inClock = ~inClock;

    phase_sequencer u_dut (
        .inClock(inClock), .Reset(Reset), .Phi1(Phi1), .Phi2(Phi2), .Phi3(Phi3), .Phi4(Phi4),
        .memReady(memReady), .haltReq(haltReq), .fetchEn(fetchEn), .decodeEn(decodeEn),
        .execEn(execEn), .writeEn(writeEn), .running(running), .halted(halted),
        .phaseError(phaseError), .instrCount(instrCount), .stallCount(stallCount)
    );

    phase_sequencer #(.COUNT_W(2)) u_dut_sat (
        .inClock(inClock), .Reset(Reset), .Phi1(Phi1), .Phi2(Phi2), .Phi3(Phi3), .Phi4(Phi4),
        .memReady(memReady), .haltReq(haltReq), .fetchEn(s_fetchEn), .decodeEn(s_decodeEn),
        .execEn(s_execEn), .writeEn(s_writeEn), .running(s_running), .halted(s_halted),
        .phaseError(s_phaseError), .instrCount(s_instrCount), .stallCount(s_stallCount)
    );

    typedef struct {
        bit [3:0] en;
        bit       run;
        bit       hal;
        bit       perr;
        int       instr;
        int       stall;
        string    tag;
    } exp_t;

    exp_t  q[$];
    int    vectors = 0;
    int    miscompares = 0;
    string cur_tag = "reset";

    // Reference model: position in the current instruction (-1 = waiting for Phi1).
    int m_pos = -1;
    bit m_halt = 0, m_err = 0, m_hp = 0;
    int m_instr = 0, m_stall = 0;
    int g = 0;

    function automatic int sat(input int x, input int mx);
        return (x > mx) ? mx : x;
    endfunction

    function automatic logic [3:0] gv();
        logic [3:0] one;
        one = 4'b0001;
        return one << g;
    endfunction

    task automatic check(input exp_t e);
        bit [3:0] a_en, s_en;
        bit bad;
        a_en = {writeEn, execEn, decodeEn, fetchEn};
        s_en = {s_writeEn, s_execEn, s_decodeEn, s_fetchEn};
        bad = (a_en != e.en) || (running != e.run) || (halted != e.hal) ||
              (phaseError != e.perr) || (int'(instrCount) != sat(e.instr, 65535)) ||
              (int'(stallCount) != sat(e.stall, 65535)) || (s_en != e.en) ||
              (s_running != e.run) || (s_halted != e.hal) || (s_phaseError != e.perr) ||
              (int'(s_instrCount) != sat(e.instr, 3)) || (int'(s_stallCount) != sat(e.stall, 3));
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL %s @%0t: got en=%b run=%b hal=%b err=%b ic=%0d sc=%0d sat(en=%b ic=%0d sc=%0d) expected en=%b run=%b hal=%b err=%b ic=%0d sc=%0d",
                     e.tag, $time, a_en, running, halted, phaseError, instrCount, stallCount,
                     s_en, s_instrCount, s_stallCount, e.en, e.run, e.hal, e.perr,
                     e.instr, e.stall);
        end
    endtask

    // Drive one cycle of inputs at a falling edge and predict outputs after the next rise.
    task automatic step(input logic [3:0] v, input bit mr, input bit hr, input bit rst);
        exp_t e;
        exp_t z;
        int   idx;
        bit   prev_rst;
        prev_rst = Reset;
        {Phi4, Phi3, Phi2, Phi1} = v;
        memReady = mr;
        haltReq  = hr;
        Reset    = rst;
        e.en = '0;
        if (!rst) begin
            m_pos = -1; m_halt = 0; m_err = 0; m_hp = 0; m_instr = 0; m_stall = 0;
        end else if (!m_halt && !m_err) begin
            if ($countones(v) != 1) begin
                m_err = 1; m_pos = -1;
            end else begin
                idx = 0;
                for (int i = 0; i < 4; i++) if (v[i]) idx = i;
                if (m_pos < 0) begin
                    if (idx == 0) begin
                        if (mr) begin m_pos = 0; e.en[0] = 1'b1; end
                        else m_stall++;
                    end
                end else if (idx != (m_pos + 1) % 4) begin
                    m_err = 1; m_pos = -1;
                end else if (m_pos == 3) begin
                    if (m_hp) begin m_halt = 1; m_pos = -1; end
                    else if (mr) begin m_pos = 0; e.en[0] = 1'b1; end
                    else begin m_pos = -1; m_stall++; end
                end else begin
                    m_pos = idx;
                    e.en[idx] = 1'b1;
                    if (idx == 3) begin m_instr++; m_hp = hr; end
                end
            end
        end
        e.run = (m_pos >= 0); e.hal = m_halt; e.perr = m_err;
        e.instr = m_instr; e.stall = m_stall; e.tag = cur_tag;
        q.push_back(e);
        if (!rst && prev_rst) begin
            // Asynchronous reset must clear outputs without waiting for a clock edge.
            #1;
            z.en = '0; z.run = 0; z.hal = 0; z.perr = 0; z.instr = 0; z.stall = 0;
            z.tag = {cur_tag, "_async"};
            check(z);
        end
        @(negedge inClock);
        g = (g + 1) % 4;
    endtask

    task automatic do_reset();
        step(gv(), 1'b1, 1'b0, 1'b0);
        step(gv(), 1'b1, 1'b0, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge inClock);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check(e);
            end
        end
    end

    initial begin : stimulus
        int  n4;
        int  dead;
        bit  mr, hr;
        logic [3:0] v;

        cur_tag = "basic";
        do_reset();
        for (int i = 0; i < 12; i++) step(gv(), 1'b1, 1'b0, 1'b1);

        cur_tag = "stall";
        for (int i = 0; i < 4; i++) step(gv(), 1'b1, 1'b0, 1'b1);
        while (g != 0) step(gv(), 1'b1, 1'b0, 1'b1);
        step(gv(), 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 11; i++) step(gv(), 1'b1, 1'b0, 1'b1);

        cur_tag = "halt";
        do_reset();
        n4 = 0;
        for (int i = 0; i < 40; i++) begin
            hr = 1'b0;
            if (g == 3 && m_pos == 2) begin
                n4++;
                hr = (n4 == 3);
            end
            step(gv(), 1'b1, hr, 1'b1);
        end

        cur_tag = "wrong_phase";
        do_reset();
        for (int i = 0; i < 10 && m_pos != 0; i++) step(gv(), 1'b1, 1'b0, 1'b1);
        step(4'b0100, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) step(gv(), 1'b1, 1'b0, 1'b1);

        cur_tag = "double_phase";
        do_reset();
        for (int i = 0; i < 6; i++) step(gv(), 1'b1, 1'b0, 1'b1);
        step(4'b0011, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step(gv(), 1'b1, 1'b0, 1'b1);

        cur_tag = "zero_after_reset";
        do_reset();
        step(4'b0000, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(gv(), 1'b1, 1'b0, 1'b1);

        cur_tag = "reset_in_exec";
        do_reset();
        for (int i = 0; i < 12 && m_pos != 2; i++) step(gv(), 1'b1, 1'b0, 1'b1);
        step(gv(), 1'b1, 1'b0, 1'b0);
        step(gv(), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(gv(), 1'b1, 1'b0, 1'b1);

        cur_tag = "random";
        do_reset();
        dead = 0;
        for (int i = 0; i < 700; i++) begin
            if (m_halt || m_err) dead++;
            if (dead > 8) begin
                dead = 0;
                do_reset();
            end
            v = gv();
            if ($urandom_range(199) == 0) v = 4'($urandom_range(15));
            mr = ($urandom_range(3) != 0);
            // Keep memReady high when a halt is about to be taken on this Phi1.
            if (m_hp && m_pos == 3 && v == 4'b0001) mr = 1'b1;
            hr = ($urandom_range(59) == 0);
            step(v, mr, hr, 1'b1);
        end

        @(posedge inClock);
        #2;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
